// File: rtl/typed_ndata_rr_select.sv
// Packet-level round-robin arbiter feeding the select stream of the typed N-stream mux.
// A grant is held until the mux reports end of packet; MAX_BURST caps consecutive packets per stream.
//
// state   | meaning
// IDLE    | no grant outstanding, searching from ptr each cycle
// GRANT   | select_valid high, select_data held until select_ready
module typed_ndata_rr_select #(
    parameter int NUM_STREAMS = 4,
    parameter int MAX_BURST   = 1,
    localparam int IDX_W      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_STREAMS-1:0] in_valid,
    output logic [IDX_W-1:0]       select_data,
    output logic                   select_valid,
    input  logic                   select_ready
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] ptr;
    logic [BC_W-1:0]  burst_cnt;

    logic             idle_found;
    logic [IDX_W-1:0] idle_pick;
    logic             rot_found;
    logic [IDX_W-1:0] rot_pick;
    logic [IDX_W-1:0] next_ptr;
    logic [BC_W:0]    nb;
    logic             stay_burst;

    // Cyclic first-set search starting at p; the wrap is modulo NUM_STREAMS, not a power of 2.
    function automatic logic [IDX_W:0] pick(input logic [IDX_W-1:0] p,
                                            input logic [NUM_STREAMS-1:0] v);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            int j;
            j = (int'(p) + k) % NUM_STREAMS;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    assign {idle_found, idle_pick} = pick(ptr, in_valid);

    assign next_ptr = (grant_idx == IDX_W'(NUM_STREAMS - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign {rot_found, rot_pick} = pick(next_ptr, in_valid);

    assign nb         = {1'b0, burst_cnt} + (BC_W+1)'(1);
    assign stay_burst = (nb < (BC_W+1)'(MAX_BURST)) && in_valid[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_found) begin
                        grant_idx <= idle_pick;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (select_ready) begin
                        if (stay_burst) begin
                            burst_cnt <= nb[BC_W-1:0];
                        end else begin
                            ptr       <= next_ptr;
                            burst_cnt <= '0;
                            if (rot_found) begin
                                grant_idx <= rot_pick;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign select_valid = (state == ST_GRANT);
    assign select_data  = grant_idx;

endmodule

// File: tb/tb_typed_ndata_rr_select.sv
// Bench for typed_ndata_rr_select: one 4-stream instance with MAX_BURST=1 and one with MAX_BURST=2.
module tb_typed_ndata_rr_select;

    logic       clk;
    logic       rst;
    logic [3:0] iv1, iv2;
    logic       rdy1, rdy2;
    logic [1:0] d1, d2;
    logic       v1, v2;

    int n_cmp;
    int n_bad;
    int exp_q[$];

    typed_ndata_rr_select #(.NUM_STREAMS(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1),
        .select_data(d1), .select_valid(v1), .select_ready(rdy1)
    );

    typed_ndata_rr_select #(.NUM_STREAMS(4), .MAX_BURST(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2),
        .select_data(d2), .select_valid(v2), .select_ready(rdy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        iv1  = '0;
        iv2  = '0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (v1 !== 1'b0 || d1 !== 2'd0 || v2 !== 1'b0 || d2 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: got v1=%0b d1=%0d v2=%0b d2=%0d expected all 0", v1, d1, v2, d2);
        end
        rdy1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (v1 !== 1'b0 || d1 !== 2'd0) begin
                n_bad++;
                $display("FAIL idle_no_req cycle %0d: got valid=%0b data=%0d expected valid=0 data=0", i, v1, d1);
            end
        end
        rdy1 = 1'b0;
        iv1  = 4'b0100;
        exp_q.push_back(2);
        step();
        n_cmp++;
        if (v1 !== 1'b1 || d1 !== 2'(exp_q.pop_front())) begin
            n_bad++;
            $display("FAIL first_grant_latency: got valid=%0b data=%0d expected valid=1 data=2", v1, d1);
        end
    endtask

    // Ready held high: every sampled valid cycle is one packet handshaken at the next edge.
    task automatic run_seq(input bit use2, input string name);
        int  cyc;
        int  e;
        logic v;
        logic [1:0] d;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            step();
            cyc++;
            v = use2 ? v2 : v1;
            d = use2 ? d2 : d1;
            e = exp_q.pop_front();
            n_cmp++;
            if (v !== 1'b1 || d !== 2'(e)) begin
                n_bad++;
                $display("FAIL %s pkt %0d: got valid=%0b data=%0d expected valid=1 data=%0d", name, cyc, v, d, e);
            end
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d pending expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rr_all_valid();
        do_reset();
        foreach (exp_q[i]) ;
        exp_q = '{0, 1, 2, 3, 0, 1};
        iv1  = 4'b1111;
        rdy1 = 1'b1;
        run_seq(1'b0, "rr_all_valid");
        rdy1 = 1'b0;
        iv1  = '0;
    endtask

    task automatic test_burst2();
        do_reset();
        exp_q = '{0, 0, 1, 1, 3, 3, 0, 0};
        iv2  = 4'b1011;
        rdy2 = 1'b1;
        run_seq(1'b1, "burst2_1011");
        rdy2 = 1'b0;
        iv2  = '0;
    endtask

    task automatic test_burst_drop();
        do_reset();
        iv2 = 4'b0011;
        step();
        n_cmp++;
        if (v2 !== 1'b1 || d2 !== 2'd0) begin
            n_bad++;
            $display("FAIL burst_drop_first: got valid=%0b data=%0d expected valid=1 data=0", v2, d2);
        end
        iv2  = 4'b0010;
        rdy2 = 1'b1;
        step();
        rdy2 = 1'b0;
        n_cmp++;
        if (v2 !== 1'b1 || d2 !== 2'd1) begin
            n_bad++;
            $display("FAIL burst_drop_rotate: got valid=%0b data=%0d expected valid=1 data=1", v2, d2);
        end
        iv2 = '0;
    endtask

    task automatic test_hold_grant();
        do_reset();
        iv1 = 4'b0010;
        step();
        iv1 = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (v1 !== 1'b1 || d1 !== 2'd1) begin
                n_bad++;
                $display("FAIL hold_grant cycle %0d: got valid=%0b data=%0d expected valid=1 data=1", i, v1, d1);
            end
        end
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release_idle: got valid=%0b expected valid=0", v1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        iv1 = 4'b1000;
        exp_q = '{3, 3, 3, 3};
        rdy1 = 1'b1;
        run_seq(1'b0, "wrap_single");
        iv1 = 4'b1001;
        step();
        rdy1 = 1'b0;
        n_cmp++;
        if (v1 !== 1'b1 || d1 !== 2'd0) begin
            n_bad++;
            $display("FAIL wrap_to_zero: got valid=%0b data=%0d expected valid=1 data=0", v1, d1);
        end
        iv1 = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        iv1 = 4'b0100;
        step();
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        n_cmp++;
        if (v1 !== 1'b1 || d1 !== 2'd2) begin
            n_bad++;
            $display("FAIL regrant_before_reset: got valid=%0b data=%0d expected valid=1 data=2", v1, d1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (v1 !== 1'b0 || d1 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mid_grant: got valid=%0b data=%0d expected valid=0 data=0", v1, d1);
        end
        iv1 = 4'b1111;
        step();
        n_cmp++;
        if (v1 !== 1'b1 || d1 !== 2'd0) begin
            n_bad++;
            $display("FAIL ptr_after_reset: got valid=%0b data=%0d expected valid=1 data=0", v1, d1);
        end
        iv1 = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_rr_all_valid();
        test_burst2();
        test_burst_drop();
        test_hold_grant();
        test_wrap();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
